mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the shared 4:1 data mux. Four requesters
//   compete for the mux. The block picks one owner, drives the 2-bit select and a
//   one-hot grant, and presents the selected input with a valid flag. An owner may
//   hold the mux for at most MAX_HOLD consecutive cycles while others are waiting.
// PARAMETERS
//   DATA_W    1   width of each mux data input and of dout
//   MAX_HOLD  4   max consecutive grant cycles per owner when others wait (>=1;
//                 1 = strict per-cycle round robin)
// PORTS
//   clk    in   1         rising-edge clock
//   rst_n  in   1         asynchronous active-low reset
//   req    in   4         request, bit i = requester i; level-sensitive
//   din0   in   DATA_W    mux data input 0
//   din1   in   DATA_W    mux data input 1
//   din2   in   DATA_W    mux data input 2
//   din3   in   DATA_W    mux data input 3
//   gnt    out  4         one-hot grant (registered); 0 when idle
//   sel    out  2         mux select = index of owner (registered)
//   valid  out  1         1 when a grant is active (registered, == |gnt)
//   dout   out  DATA_W    din[sel] when valid, else 0 (combinational from sel)
// BEHAVIOUR
//   - Reset (async, rst_n=0): gnt=0, sel=0, valid=0, dout=0, state=IDLE, hold_cnt=0.
//     The last pointer resets to 3, so requester 0 has top priority after reset.
//     Reset mid-grant clears the outputs immediately, without waiting for a clock edge.
//   - State IDLE: if |req at an edge, the block grants winner w and loads gnt=1<<w,
//     sel=w, valid=1, hold_cnt=1, last=w, and moves to GRANT.
//     Winner w = first i with req[i]=1, searching last+1, last+2, ... mod 4.
//     If req=0, the block stays in IDLE.
//     Latency from req rising to gnt is 1 clock.
//   - State GRANT with owner o = sel:
//     a) req[o]=0 (release): if other requests are pending, grant the next winner
//        searched from o+1 in the same edge. There is no idle bubble. Otherwise
//        gnt=0, valid=0, and the state returns to IDLE. sel keeps its last value.
//     b) req[o]=1, hold_cnt<MAX_HOLD: keep the grant and increment hold_cnt.
//     c) req[o]=1, hold_cnt==MAX_HOLD, other req pending: preempt and grant the next
//        winner searched from o+1. hold_cnt=1.
//     d) req[o]=1, hold_cnt==MAX_HOLD, no other req: keep the grant. hold_cnt
//        saturates at MAX_HOLD, so a new request later preempts on the next edge.
//   - Every new grant updates last to the new owner and reloads hold_cnt to 1.
//   - Simultaneous requests: only the round-robin order decides. There are no fixed
//     priorities beyond that.
//   - gnt is always one-hot or zero. valid==|gnt. sel==index(gnt) whenever valid.
//   - hold_cnt width is clog2(MAX_HOLD+1). Wrap of last/search indices is mod 4.
//   - dout is a pure mux of din0..din3 by sel, gated by valid. There is no extra
//     register, so dout follows din changes within the same cycle.
// TESTING
//   1. Reset: rst_n=0 with req=4'b1111 -> gnt=0, sel=0, valid=0, dout=0. Release
//      rst_n and wait 1 clk -> gnt=4'b0001, sel=0.
//   2. Round robin, MAX_HOLD=1, req=4'b1111 held -> gnt sequence 0001, 0010, 0100,
//      1000, 0001 on consecutive edges; dout tracks din0..din3 (e.g. 0,1,1,0).
//   3. Hold limit, MAX_HOLD=4: req=4'b0001 alone for 6 clk -> gnt stays 0001.
//      Then assert req[2] -> gnt=0100 on the next edge (hold_cnt saturated).
//   4. Release handoff: owner 1 drops req[1] while req[3]=1 -> gnt goes 0010->1000
//      in one edge. valid stays 1 and there is no idle cycle.
//   5. Idle: all req drop -> gnt=0, valid=0, dout=0 next edge; sel holds the last
//      value. A later req=4'b0110 after owner 3 -> grant 1 (search from 0 finds 1).
//   6. Mid-grant reset: pulse rst_n low between edges while gnt=0100 -> outputs go
//      to 0 asynchronously. The first grant after reset goes to the lowest
//      requesting index.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 data mux.
// Grants are registered; dout is a combinational mux gated by valid.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic              valid,
    output logic [DATA_W-1:0] dout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [1:0]    last;
    logic [CW-1:0] hold_cnt;

    logic [3:0]    cand;
    logic [1:0]    base;
    logic [1:0]    win;
    logic [1:0]    idx;
    logic          found;

    // While granted, the owner is masked so only competitors can win
    always_comb begin
        cand  = req;
        base  = last;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        if (state == GRANT) begin
            cand[sel] = 1'b0;
            base      = sel;
        end
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
            last     <= 2'd3;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= 4'b0001 << win;
                        sel      <= win;
                        valid    <= 1'b1;
                        hold_cnt <= CW'(1);
                        last     <= win;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[sel] && !found) begin
                        gnt   <= '0;
                        valid <= 1'b0;
                        state <= IDLE;
                    end else if (req[sel] && hold_cnt < CW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end else if (found) begin
                        gnt      <= 4'b0001 << win;
                        sel      <= win;
                        valid    <= 1'b1;
                        hold_cnt <= CW'(1);
                        last     <= win;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        if (valid) begin
            unique case (sel)
                2'd0: dout = din0;
                2'd1: dout = din1;
                2'd2: dout = din2;
                2'd3: dout = din3;
                default: dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: dut_a uses MAX_HOLD=1, dut_b uses MAX_HOLD=4.
// Stimulus queues expected outputs; a negedge monitor pops and checks.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       din0, din1, din2, din3;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b;
    logic       dout_a, dout_b;

    int tests;
    int fails;
    int cyc;

    typedef struct {
        int         cyc;
        bit         which;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];

    mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt_a), .sel(sel_a), .valid(valid_a), .dout(dout_a)
    );

    mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt_b), .sel(sel_b), .valid(valid_b), .dout(dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pack(bit w);
        if (w) return {gnt_b, sel_b, valid_b, dout_b};
        return {gnt_a, sel_a, valid_a, dout_a};
    endfunction

    task automatic sb_push(string n, bit w, logic [3:0] g,
                           logic [1:0] s, logic v, logic d);
        exp_t e;
        e.cyc   = cyc + 1;
        e.which = w;
        e.val   = {g, s, v, d};
        e.name  = n;
        q.push_back(e);
    endtask

    task automatic check_now(string n, logic [7:0] act, logic [7:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got gnt/sel/valid/dout=%b required %b",
                     n, act, req_v);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check_now(e.name, pack(e.which), e.val);
        end
    end

    task automatic drive(logic [3:0] ra, logic [3:0] rb);
        @(negedge clk);
        #1;
        req_a = ra;
        req_b = rb;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req_a = 4'b1111;
        req_b = 4'b1111;
        din0 = 1'b0; din1 = 1'b1; din2 = 1'b1; din3 = 1'b0;

        #12;
        check_now("reset_a", pack(0), 8'b0);
        check_now("reset_b", pack(1), 8'b0);

        @(negedge clk);
        #1;
        rst_n = 1'b1;
        sb_push("rr_a_0", 0, 4'b0001, 2'd0, 1, 0);
        sb_push("first_b", 1, 4'b0001, 2'd0, 1, 0);

        drive(4'b1111, 4'b0001);
        sb_push("rr_a_1", 0, 4'b0010, 2'd1, 1, 1);
        sb_push("hold_b_2", 1, 4'b0001, 2'd0, 1, 0);
        drive(4'b1111, 4'b0001);
        sb_push("rr_a_2", 0, 4'b0100, 2'd2, 1, 1);
        sb_push("hold_b_3", 1, 4'b0001, 2'd0, 1, 0);
        drive(4'b1111, 4'b0001);
        sb_push("rr_a_3", 0, 4'b1000, 2'd3, 1, 0);
        sb_push("hold_b_4", 1, 4'b0001, 2'd0, 1, 0);
        drive(4'b1111, 4'b0001);
        sb_push("rr_a_wrap", 0, 4'b0001, 2'd0, 1, 0);
        sb_push("hold_b_sat1", 1, 4'b0001, 2'd0, 1, 0);
        drive(4'b1111, 4'b0001);
        sb_push("rr_a_5", 0, 4'b0010, 2'd1, 1, 1);
        sb_push("hold_b_sat2", 1, 4'b0001, 2'd0, 1, 0);
        drive(4'b1111, 4'b0001);
        sb_push("rr_a_6", 0, 4'b0100, 2'd2, 1, 1);
        sb_push("hold_b_sat3", 1, 4'b0001, 2'd0, 1, 0);

        drive(4'b1111, 4'b0101);
        sb_push("rr_a_7", 0, 4'b1000, 2'd3, 1, 0);
        sb_push("preempt_b", 1, 4'b0100, 2'd2, 1, 1);

        drive(4'b1010, 4'b0101);
        sb_push("preempt_a_to1", 0, 4'b0010, 2'd1, 1, 1);
        sb_push("keep_b_2", 1, 4'b0100, 2'd2, 1, 1);
        drive(4'b1000, 4'b0101);
        sb_push("handoff_a", 0, 4'b1000, 2'd3, 1, 0);
        sb_push("keep_b_3", 1, 4'b0100, 2'd2, 1, 1);

        drive(4'b0000, 4'b0101);
        sb_push("idle_a", 0, 4'b0000, 2'd3, 0, 0);
        sb_push("keep_b_4", 1, 4'b0100, 2'd2, 1, 1);
        drive(4'b0110, 4'b0101);
        sb_push("idle_regrant_a", 0, 4'b0010, 2'd1, 1, 1);
        sb_push("preempt_b_wrap", 1, 4'b0001, 2'd0, 1, 0);
        drive(4'b0110, 4'b0101);
        sb_push("rr_a_to2", 0, 4'b0100, 2'd2, 1, 1);
        sb_push("keep_b_0", 1, 4'b0001, 2'd0, 1, 0);

        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now("async_rst_a", pack(0), 8'b0);
        check_now("async_rst_b", pack(1), 8'b0);
        rst_n = 1'b1;
        sb_push("post_rst_a", 0, 4'b0010, 2'd1, 1, 1);
        sb_push("post_rst_b", 1, 4'b0001, 2'd0, 1, 0);

        drive(4'b0110, 4'b0101);
        din1 = 1'b0;
        #1;
        check_now("dout_comb_a", pack(0), {4'b0010, 2'd1, 1'b1, 1'b0});
        sb_push("rr_a_after", 0, 4'b0100, 2'd2, 1, 1);
        sb_push("keep_b_after", 1, 4'b0001, 2'd0, 1, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
